// File: rtl/johnson_phase_monitor.sv
// rtl/johnson_phase_monitor.sv - Johnson code phase decoder with successor checking and lock FSM
// Optional error counter: define JOHNSON_PHASE_MONITOR_ERRCNT_EN to add err_count.
module johnson_phase_monitor #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3
`ifdef JOHNSON_PHASE_MONITOR_ERRCNT_EN
  , parameter int CNT_W  = 8
`endif
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N-1:0]            Q,
  output logic [2*N-1:0]          phase,
  output logic [$clog2(2*N)-1:0]  phase_idx,
  output logic                    legal,
  output logic                    seq_err,
  output logic                    illegal,
  output logic                    locked
`ifdef JOHNSON_PHASE_MONITOR_ERRCNT_EN
  , output logic [CNT_W-1:0]      err_count
`endif
);

  localparam int IW = $clog2(2*N);
  localparam int GW = $clog2(LOCK_CNT+1);
  localparam logic [IW-1:0] LAST_IDX = IW'(2*N-1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   good_cnt, good_cnt_nxt, good_inc;
  logic            dec_legal;
  logic [IW-1:0]   dec_idx;
  logic [IW-1:0]   next_idx;
  logic            succ;
  logic            seq_nxt;
  logic [2*N-1:0]  phase_nxt;

  // Legal code for index k: k ones filling up from bit 0, then zeros filling up from bit 0.
  function automatic logic [N-1:0] code_of(input int k);
    logic [N-1:0] c;
    for (int b = 0; b < N; b++) begin
      c[b] = (k <= N) ? (b < k) : (b >= k - N);
    end
    return c;
  endfunction

  // Decode the incoming code against every legal Johnson pattern.
  always_comb begin
    dec_legal = 1'b0;
    dec_idx   = '0;
    for (int k = 0; k < 2*N; k++) begin
      if (Q == code_of(k)) begin
        dec_legal = 1'b1;
        dec_idx   = IW'(k);
      end
    end
    phase_nxt = {{(2*N-1){1'b0}}, 1'b1} << dec_idx;
  end

  // phase_idx only moves on legal samples, so it doubles as the previous legal index.
  always_comb begin
    next_idx = (phase_idx == LAST_IDX) ? '0 : phase_idx + 1'b1;
    succ     = (dec_idx == next_idx);
    good_inc = good_cnt + 1'b1;
  end

  // Lock FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else if (en) begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
    end
  end

  // Lock FSM next-state: any illegal code drops back to SEARCH; a legal miss re-anchors in TRACK.
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    seq_nxt      = 1'b0;
    if (!dec_legal) begin
      state_nxt    = SEARCH;
      good_cnt_nxt = '0;
    end else begin
      case (state)
        SEARCH: begin
          state_nxt    = TRACK;
          good_cnt_nxt = '0;
        end
        TRACK: begin
          if (succ) begin
            good_cnt_nxt = good_inc;
            if (good_inc == GW'(LOCK_CNT)) state_nxt = LOCKED;
          end else begin
            seq_nxt      = 1'b1;
            good_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          if (!succ) begin
            seq_nxt      = 1'b1;
            state_nxt    = TRACK;
            good_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = SEARCH;
          good_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Lock FSM output decode from the registered state.
  always_comb begin
    locked = (state == LOCKED);
  end

  // Registered phase outputs; pulses are cleared whenever sampling is frozen.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase     <= '0;
      phase_idx <= '0;
      legal     <= 1'b0;
      seq_err   <= 1'b0;
      illegal   <= 1'b0;
    end else if (en) begin
      legal   <= dec_legal;
      illegal <= !dec_legal;
      seq_err <= seq_nxt;
      if (dec_legal) begin
        phase     <= phase_nxt;
        phase_idx <= dec_idx;
      end else begin
        phase     <= '0;
      end
    end else begin
      seq_err <= 1'b0;
      illegal <= 1'b0;
    end
  end

`ifdef JOHNSON_PHASE_MONITOR_ERRCNT_EN
  // Saturating count of sequence and illegal-code events.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_count <= '0;
    end else if (en && (seq_nxt || !dec_legal) && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// tb/tb_johnson_phase_monitor.sv - self-checking bench for johnson_phase_monitor
module tb_johnson_phase_monitor;

  localparam int N        = 4;
  localparam int LOCK_CNT = 3;
`ifdef JOHNSON_PHASE_MONITOR_ERRCNT_EN
  localparam int CNT_W    = 2;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         en    = 1'b0;
  logic [N-1:0] Q     = '0;
  logic [2*N-1:0] phase;
  logic [2:0]   phase_idx;
  logic         legal, seq_err, illegal, locked;
`ifdef JOHNSON_PHASE_MONITOR_ERRCNT_EN
  logic [CNT_W-1:0] err_count;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  johnson_phase_monitor #(
    .N(N), .LOCK_CNT(LOCK_CNT)
`ifdef JOHNSON_PHASE_MONITOR_ERRCNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clock(clock), .reset(reset), .en(en), .Q(Q),
    .phase(phase), .phase_idx(phase_idx), .legal(legal),
    .seq_err(seq_err), .illegal(illegal), .locked(locked)
`ifdef JOHNSON_PHASE_MONITOR_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: classify a code by its population count rather than by pattern table.
  function automatic void decode(input logic [N-1:0] q, output bit ok, output int k);
    int c;
    c  = $countones(q);
    ok = 1'b0;
    k  = 0;
    if (q == N'((1 << c) - 1)) begin
      ok = 1'b1; k = c;
    end else if (q == N'(~((1 << (N - c)) - 1))) begin
      ok = 1'b1; k = 2*N - c;
    end
  endfunction

  int  m_idx, streak, mk;
  bit  anchored, m_legal, m_seq, m_ill, mok;
  logic [2*N-1:0] m_phase;
  int  m_err;

  // Model: a streak of successors since the last anchor; locked once the streak reaches LOCK_CNT.
  always @(posedge clock) begin
    if (reset) begin
      m_idx = 0; streak = 0; anchored = 0; m_legal = 0; m_seq = 0; m_ill = 0;
      m_phase = '0; m_err = 0;
    end else if (en) begin
      decode(Q, mok, mk);
      m_seq = 0; m_ill = 0;
      if (!mok) begin
        m_ill = 1; m_legal = 0; m_phase = '0; anchored = 0; streak = 0;
      end else begin
        if (!anchored) begin
          anchored = 1; streak = 0;
        end else if (mk == (m_idx + 1) % (2*N)) begin
          streak++;
        end else begin
          m_seq = 1; streak = 0;
        end
        m_idx = mk; m_legal = 1; m_phase = '0; m_phase[mk] = 1'b1;
      end
`ifdef JOHNSON_PHASE_MONITOR_ERRCNT_EN
      if ((m_seq || m_ill) && m_err < (1 << CNT_W) - 1) m_err++;
`endif
    end else begin
      m_seq = 0; m_ill = 0;
    end
  end

  // Compare every cycle once reset has been applied.
  always @(negedge clock) begin
    if (chk_on) begin
      check("phase", 32'(phase), 32'(m_phase));
      check("phase_idx", 32'(phase_idx), 32'(m_idx));
      check("legal", 32'(legal), 32'(m_legal));
      check("seq_err", 32'(seq_err), 32'(m_seq));
      check("illegal", 32'(illegal), 32'(m_ill));
      check("locked", 32'(locked), 32'(anchored && streak >= LOCK_CNT));
`ifdef JOHNSON_PHASE_MONITOR_ERRCNT_EN
      check("err_count", 32'(err_count), 32'(m_err));
`endif
    end
  end

  task automatic step(input logic [N-1:0] q, input logic e);
    Q = q; en = e;
    @(posedge clock); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; en = 1;
    @(posedge clock); #2;
    chk_on = 1;
    @(posedge clock); #2;
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_legal", 32'(legal), 32'h0);
    reset = 0;

    // Clean run with wrap.
    step(4'b0000, 1); check("c0_phase", 32'(phase), 32'h01);
    step(4'b0001, 1); check("c1_idx", 32'(phase_idx), 1);
    step(4'b0011, 1); check("c2_locked", 32'(locked), 0);
    step(4'b0111, 1); check("c3_locked", 32'(locked), 1);
    step(4'b1111, 1); check("c4_phase", 32'(phase), 32'h10);
    step(4'b1110, 1);
    step(4'b1100, 1);
    step(4'b1000, 1); check("c7_idx", 32'(phase_idx), 7);
    step(4'b0000, 1); check("wrap_seq", 32'(seq_err), 0);
                      check("wrap_idx", 32'(phase_idx), 0);
                      check("wrap_locked", 32'(locked), 1);

    // Illegal code while locked.
    step(4'b0001, 1);
    step(4'b0101, 1); check("ill_pulse", 32'(illegal), 1);
                      check("ill_phase", 32'(phase), 0);
                      check("ill_locked", 32'(locked), 0);
                      check("ill_idx", 32'(phase_idx), 1);
    step(4'b0011, 1); check("ill_clear", 32'(illegal), 0);
    step(4'b0111, 1);
    step(4'b1111, 1); check("rl_pre", 32'(locked), 0);
    step(4'b1110, 1); check("rl_post", 32'(locked), 1);

    // Skip while locked.
    step(4'b1100, 1); step(4'b1000, 1); step(4'b0000, 1); step(4'b0001, 1);
    step(4'b0111, 1); check("skip_seq", 32'(seq_err), 1);
                      check("skip_locked", 32'(locked), 0);
                      check("skip_idx", 32'(phase_idx), 3);
    step(4'b1111, 1); check("skip_clear", 32'(seq_err), 0);
    step(4'b1110, 1);
    step(4'b1100, 1); check("skip_relock", 32'(locked), 1);

    // Stuck code.
    step(4'b1000, 1); step(4'b0000, 1); step(4'b0001, 1);
    step(4'b0011, 1); check("stuck1_seq", 32'(seq_err), 0);
    step(4'b0011, 1); check("stuck2_seq", 32'(seq_err), 1);
    step(4'b0011, 1); check("stuck3_seq", 32'(seq_err), 1);
                      check("stuck_locked", 32'(locked), 0);
    step(4'b0111, 1); step(4'b1111, 1); step(4'b1110, 1);
    check("stuck_relock", 32'(locked), 1);

    // Frozen while en=0.
    step(4'b0101, 0); step(4'b1111, 0); step(4'b0000, 0); step(4'b1010, 0);
    step(4'b0110, 0); check("frz_ill", 32'(illegal), 0);
                      check("frz_idx", 32'(phase_idx), 5);
                      check("frz_locked", 32'(locked), 1);
    step(4'b1100, 1); check("frz_seq", 32'(seq_err), 0);
                      check("frz_keep", 32'(locked), 1);

`ifdef JOHNSON_PHASE_MONITOR_ERRCNT_EN
    // Saturating counter from a fresh reset.
    reset = 1; step(4'b0000, 1); reset = 0;
    check("cnt_rst", 32'(err_count), 0);
    step(4'b0101, 1); check("cnt1", 32'(err_count), 1);
    step(4'b1010, 1); check("cnt2", 32'(err_count), 2);
    step(4'b0110, 1); check("cnt3", 32'(err_count), 3);
    step(4'b1001, 1); check("cnt_sat", 32'(err_count), 3);
`endif

    // Reset mid-lock, asserted with en low.
    step(4'b0000, 1); step(4'b0001, 1); step(4'b0011, 1); step(4'b0111, 1);
    check("pre_rst_locked", 32'(locked), 1);
    reset = 1; step(4'b1111, 0);
    check("mrst_phase", 32'(phase), 0);
    check("mrst_idx", 32'(phase_idx), 0);
    check("mrst_legal", 32'(legal), 0);
    check("mrst_locked", 32'(locked), 0);
`ifdef JOHNSON_PHASE_MONITOR_ERRCNT_EN
    check("mrst_cnt", 32'(err_count), 0);
`endif
    reset = 0;
    step(4'b1111, 1); check("post_idx", 32'(phase_idx), 4);
                      check("post_seq", 32'(seq_err), 0);
    step(4'b1100, 1); check("post_seq2", 32'(seq_err), 1);

    @(negedge clock); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Sits directly downstream of the N-bit Johnson (twisted-ring) counter and consumes its Q bus.
- Decodes each Johnson code into a registered one-hot phase vector and a binary phase index.
- Checks each code is legal and is the exact successor of the previous sample.
- Tracks lock status through a small state machine, giving downstream logic clean phase strobes plus a health indication.

Parameters:
- N, 4, Johnson register width (N >= 2); 2N legal codes.
- LOCK_CNT, 3, consecutive correct successor steps required to declare lock (>= 1).
- CNT_W, 8, width of error counter (Optional Feature only).

Ports:
- clock  input  1  rising-edge clock, same clock as the upstream counter.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample enable; low = block frozen (no sample, no state change).
- Q  input  N  Johnson code from upstream counter.
- phase  output  2N  registered one-hot phase; bit k set when Q decodes to index k.
- phase_idx  output  $clog2(2N)  registered binary index of current code.
- legal  output  1  registered; last sample was a legal Johnson code.
- seq_err  output  1  one-cycle pulse; legal sample that was not successor of previous legal sample.
- illegal  output  1  one-cycle pulse; sample was not a legal Johnson code.
- locked  output  1  high while FSM is in LOCKED.
- err_count  output  CNT_W  saturating error count (Optional Feature only).

Behaviour:
- Reset (synchronous, edge with reset=1): phase=0, phase_idx=0, legal=0, seq_err=0, illegal=0, locked=0, err_count=0, FSM=SEARCH, good_cnt=0, stored prev_idx=0. Reset wins over en.
- Sampling: on each rising edge with en=1 and reset=0, Q is sampled; all outputs reflect that sample after the same edge (1-cycle latency from Q to outputs).
- en=0: all registers hold; seq_err and illegal forced to 0 (pulses never repeat while frozen).
- Legal codes and index k:
  - k in 0..N: the low k bits are 1, the rest 0 (k=0 is all zeros, k=N is all ones).
  - k in N+1..2N-1: the low k-N bits are 0, the rest 1.
  - Successor of k is (k+1) mod 2N. Wrap 2N-1 -> 0 (e.g. N=4: 1000 -> 0000) is a legal step.
- Illegal sample:
  - phase=0, legal=0, illegal=1.
  - phase_idx holds its previous value.
  - prev_idx is not updated.
- Legal sample: phase=one-hot(k), phase_idx=k, legal=1, prev_idx<=k.
- FSM (good_cnt counts consecutive successors):
  - SEARCH:
    - legal -> TRACK, good_cnt=0, no seq_err.
    - illegal -> stay.
  - TRACK:
    - successor: good_cnt+1. If the new good_cnt equals LOCK_CNT -> LOCKED, else stay.
    - legal non-successor (including repeated identical code): seq_err=1, good_cnt=0, stay in TRACK, re-anchor on new k.
    - illegal -> SEARCH, good_cnt=0.
  - LOCKED:
    - successor -> stay.
    - legal non-successor -> seq_err=1, TRACK, good_cnt=0.
    - illegal -> SEARCH.
- locked is the registered FSM state; it drops on the same edge that detects the error.
- seq_err and illegal are mutually exclusive.

Optional Feature:
- Macro: JOHNSON_PHASE_MONITOR_ERRCNT_EN.
- Defined:
  - err_count port exists.
  - Increments by 1 on each edge where seq_err or illegal is asserted.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; holds while en=0.
- Undefined: err_count port and counter logic are absent; all other behaviour is identical.

Test Plan (N=4, LOCK_CNT=3):
- Clean run: reset 2 cycles, then Q follows 0000,0001,0011,0111,1111,1110,1100,1000,0000, en=1.
  - Expected: phase_idx 0,1,2,...,7,0 one cycle after each code; phase=8'b00000001,00000010,...
  - locked rises after the 4th sample (0111); no seq_err across the 1000->0000 wrap.
- Illegal code while locked: inject Q=0101.
  - Expected on that edge: illegal=1 for one cycle, phase=0, legal=0, locked=0, FSM=SEARCH, phase_idx unchanged.
  - Then 0011,0111,1111,1110 relocks on the 4th good sample.
- Skip while locked: 0001 -> 0111.
  - Expected: seq_err=1 for one cycle, locked=0, phase_idx=3.
  - Then 1111,1110,1100 relocks (locked=1 after 1100).
- Stuck code: hold Q=0011 for 3 cycles after locking.
  - Expected: seq_err on the 2nd and 3rd samples; locked=0.
- en gating: en=0 for 5 cycles while Q changes arbitrarily.
  - Expected: all outputs frozen, no pulses.
  - On en=1 with the successor of the last sampled index: no seq_err, lock retained.
- Reset mid-lock plus counter (macro defined, CNT_W=2):
  - Expected: 4 illegal samples give err_count 1,2,3,3 (saturates).
  - Synchronous reset then clears all outputs to the reset values on that edge.
